// File: rtl/cnnip_arb_pkg.sv
// Shared types and defaults for the block-memory port arbiter.
//   arb_state_e : arbiter FSM states (ARB, RD_WAIT)
//   ptr_w()     : width of a requester index (never less than 1)
//   DEF_*       : default parameter values for the arbiter
package cnnip_arb_pkg;

    localparam int unsigned DEF_NUM_REQ      = 4;
    localparam int unsigned DEF_ADDR_WIDTH   = 16;
    localparam int unsigned DEF_DATA_WIDTH   = 32;
    localparam int unsigned DEF_READ_LATENCY = 3;

    typedef enum logic [0:0] {
        ARB     = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_e;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/cnnip_mem_if.sv
// Master/slave bundle between an access client and the block-memory wrapper.
//   en, we, addr (byte address), din : client -> wrapper
//   dout, valid                      : wrapper -> client (valid pulses once per read)
interface cnnip_mem_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;

    modport master (output en, output we, output addr, output din,
                    input  dout, input valid);
    modport slave  (input  en, input we, input addr, input din,
                    output dout, output valid);
endinterface

// File: rtl/cnnip_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo NUM_REQ.
//   req_i    : request vector
//   ptr_i    : highest-priority index
//   onehot_o : winner as a one-hot vector
//   idx_o    : winner index
//   any_o    : at least one request asserted
module cnnip_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);

    logic [PTR_W-1:0] cand;

    // Scan from ptr_i upward; the first hit wins and blocks later candidates.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((32'(ptr_i) + i) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o          = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnnip_mem_arbiter.sv
// Round-robin arbiter sharing one block-memory wrapper port among NUM_REQ
// requesters. Writes take one cycle; a read holds the port until the
// wrapper's valid pulse and the data is returned to the issuing requester.
//   clk_a, arstz_aq   : clock, synchronous active-low reset
//   req/req_we/req_addr/req_din : per-requester access, held until gnt
//   gnt               : one-hot accept pulse (combinational, same cycle)
//   rvalid/rdata      : registered read return, rvalid one-hot
//   busy              : a read is outstanding
//   mem_if            : master side toward the memory wrapper
module cnnip_mem_arbiter
    import cnnip_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic                               clk_a,
    input  logic                               arstz_aq,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ-1:0]                 req_we,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_din,
    output logic [NUM_REQ-1:0]                 gnt,
    output logic [NUM_REQ-1:0]                 rvalid,
    output logic [DATA_WIDTH-1:0]              rdata,
    output logic                               busy,
    cnnip_mem_if.master                        mem_if
);

    localparam int unsigned PTR_W = ptr_w(NUM_REQ);
    localparam int unsigned CNT_W = ptr_w(READ_LATENCY + 2);

    arb_state_e             state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [NUM_REQ-1:0]     rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NUM_REQ-1:0]     pick_onehot;
    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_any;

    logic [NUM_REQ-1:0]     gnt_c;
    logic                   en_c;
    logic                   we_c;
    logic [ADDR_WIDTH-1:0]  addr_c;
    logic [DATA_WIDTH-1:0]  din_c;

    cnnip_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // Next-state and memory-port drive.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        owner_d  = owner_q;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        gnt_c    = '0;
        en_c     = 1'b0;
        we_c     = 1'b0;
        addr_c   = '0;
        din_c    = '0;

        case (state_q)
            ARB: begin
                // mem_if.valid is ignored here (stale pulse after a reset mid-read).
                if (pick_any) begin
                    gnt_c  = pick_onehot;
                    en_c   = 1'b1;
                    we_c   = req_we[pick_idx];
                    addr_c = req_addr[pick_idx];
                    din_c  = req_din[pick_idx];
                    ptr_d  = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                : PTR_W'(pick_idx + 1'b1);
                    if (!req_we[pick_idx]) begin
                        addr_d  = req_addr[pick_idx];
                        owner_d = pick_idx;
                        cnt_d   = CNT_W'(1);
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // Address stays put while the wrapper keeps the memory enabled.
                addr_c = addr_q;
                if (mem_if.valid) begin
                    rdata_d           = mem_if.dout;
                    rvalid_d[owner_q] = 1'b1;
                    cnt_d             = '0;
                    state_d           = ARB;
                end else if (cnt_q < CNT_W'(READ_LATENCY + 1)) begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            default: state_d = ARB;
        endcase

        // Nothing leaves the block while reset is held.
        if (!arstz_aq) begin
            gnt_c  = '0;
            en_c   = 1'b0;
            we_c   = 1'b0;
            addr_c = '0;
            din_c  = '0;
        end
    end

    // State, pointer, read latches and registered return path.
    always_ff @(posedge clk_a) begin
        if (!arstz_aq) begin
            state_q  <= ARB;
            ptr_q    <= '0;
            addr_q   <= '0;
            owner_q  <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            owner_q  <= owner_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    // Protocol checks toward the wrapper.
    always_ff @(posedge clk_a) begin
        if (arstz_aq) begin
            spurious_valid: assert (!(state_q == ARB && mem_if.valid));
            read_timeout: assert (!(state_q == RD_WAIT && !mem_if.valid &&
                                    cnt_q >= CNT_W'(READ_LATENCY)));
        end
    end

    assign gnt         = gnt_c;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign busy        = (state_q == RD_WAIT);
    assign mem_if.en   = en_c;
    assign mem_if.we   = we_c;
    assign mem_if.addr = addr_c;
    assign mem_if.din  = din_c;

endmodule

// File: tb/tb_cnnip_mem_arbiter.sv
// Scoreboard bench for cnnip_mem_arbiter with a behavioural memory wrapper.
module tb_cnnip_mem_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned RL = 3;

    localparam int PK_RST  = 0;
    localparam int PK_BUSY = 1;
    localparam int PK_ADDR = 2;
    localparam int PK_EN   = 3;
    localparam int PK_NORV = 4;

    typedef struct { int cyc; int idx; logic [AW-1:0] addr; logic we; logic [DW-1:0] din; } gexp_t;
    typedef struct { int cyc; int idx; logic [DW-1:0] data; } rexp_t;
    typedef struct { int cyc; int kind; logic [31:0] val; } probe_t;

    logic                       clk = 1'b0;
    logic                       arstz;
    logic [NR-1:0]              req;
    logic [NR-1:0]              req_we;
    logic [NR-1:0][AW-1:0]      req_addr;
    logic [NR-1:0][DW-1:0]      req_din;
    logic [NR-1:0]              gnt;
    logic [NR-1:0]              rvalid;
    logic [DW-1:0]              rdata;
    logic                       busy;

    logic [NR-1:0]              sticky;
    logic [NR-1:0]              g_last = '0;
    logic                       inj_valid;
    logic [DW-1:0]              inj_data;
    logic                       done;
    int                         cyc = 0;
    int                         checks = 0;
    int                         errors = 0;

    gexp_t  gq[$];
    rexp_t  rq[$];
    probe_t pq[$];

    // Behavioural wrapper state
    logic [DW-1:0] mem [0:255];
    logic          preloaded = 1'b0;
    logic [7:0]    m_addr = '0;
    int            m_cnt = 0;
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_dout = '0;

    cnnip_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

    cnnip_mem_arbiter #(
        .NUM_REQ      (NR),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL)
    ) dut (
        .clk_a    (clk),
        .arstz_aq (arstz),
        .req      (req),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_din  (req_din),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .busy     (busy),
        .mem_if   (mif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mif.valid = m_valid | inj_valid;
    assign mif.dout  = inj_valid ? inj_data : m_dout;

    // Wrapper model: valid/dout RL cycles after a read enable, reset with the arbiter.
    always @(posedge clk) begin
        if (!preloaded) begin
            mem[8'h20] <= 32'hDEAD_BEEF;
            preloaded  <= 1'b1;
        end
        m_valid <= 1'b0;
        if (!arstz) begin
            m_cnt <= 0;
        end else begin
            if (m_cnt == 1) begin
                m_valid <= 1'b1;
                m_dout  <= mem[m_addr];
                m_cnt   <= 0;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end
            if (mif.en && mif.we) mem[mif.addr[9:2]] <= mif.din;
            if (mif.en && !mif.we) begin
                m_addr <= mif.addr[9:2];
                m_cnt  <= int'(RL) - 1;
            end
        end
    end

    task automatic push_g(input int c, input int idx, input logic [AW-1:0] a,
                          input logic w, input logic [DW-1:0] d);
        gexp_t e;
        e.cyc = c; e.idx = idx; e.addr = a; e.we = w; e.din = d;
        gq.push_back(e);
    endtask

    task automatic push_r(input int c, input int idx, input logic [DW-1:0] d);
        rexp_t e;
        e.cyc = c; e.idx = idx; e.data = d;
        rq.push_back(e);
    endtask

    task automatic push_p(input int c, input int kind, input logic [31:0] v);
        probe_t e;
        e.cyc = c; e.kind = kind; e.val = v;
        pq.push_back(e);
    endtask

    // Advance one cycle; granted requesters drop req, sticky ones re-request.
    task automatic step();
        @(posedge clk);
        #1;
        req = (req & ~g_last) | sticky;
    endtask

    // Monitor: pops expectations whenever the DUT presents gnt/rvalid, plus timed probes.
    always @(negedge clk) begin
        gexp_t         ge;
        rexp_t         re;
        probe_t        pe;
        logic [NR-1:0] oh;
        logic [31:0]   act;

        g_last = gnt;

        if (gnt != '0) begin
            checks++;
            if (gq.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected cyc=%0d got gnt=%b required none", cyc, gnt);
            end else begin
                ge = gq.pop_front();
                oh = NR'(1) << ge.idx;
                if (gnt !== oh || cyc != ge.cyc || mif.en !== 1'b1 || mif.we !== ge.we ||
                    mif.addr !== ge.addr || mif.din !== ge.din) begin
                    errors++;
                    $display("FAIL grant cyc=%0d got gnt=%b en=%b we=%b addr=%h din=%h required cyc=%0d gnt=%b en=1 we=%b addr=%h din=%h",
                             cyc, gnt, mif.en, mif.we, mif.addr, mif.din,
                             ge.cyc, oh, ge.we, ge.addr, ge.din);
                end
            end
        end

        if (rvalid != '0) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected cyc=%0d got rvalid=%b rdata=%h required none", cyc, rvalid, rdata);
            end else begin
                re = rq.pop_front();
                oh = NR'(1) << re.idx;
                if (rvalid !== oh || cyc != re.cyc || rdata !== re.data) begin
                    errors++;
                    $display("FAIL read_return cyc=%0d got rvalid=%b rdata=%h required cyc=%0d rvalid=%b rdata=%h",
                             cyc, rvalid, rdata, re.cyc, oh, re.data);
                end
            end
        end

        while (pq.size() > 0 && pq[0].cyc <= cyc) begin
            pe = pq.pop_front();
            case (pe.kind)
                PK_RST:  act = 32'({gnt, rvalid, mif.en, mif.we, busy, |mif.addr, |mif.din, |rdata});
                PK_BUSY: act = 32'(busy);
                PK_ADDR: act = 32'(mif.addr);
                PK_EN:   act = 32'(mif.en);
                default: act = 32'(rvalid);
            endcase
            checks++;
            if (pe.cyc != cyc || act !== pe.val) begin
                errors++;
                $display("FAIL probe_kind%0d cyc=%0d got %h required %h at cyc=%0d",
                         pe.kind, cyc, act, pe.val, pe.cyc);
            end
        end

        if (done) begin
            checks++;
            if (gq.size() != 0) begin
                errors++;
                $display("FAIL grants_missing got %0d pending required 0", gq.size());
            end
            checks++;
            if (rq.size() != 0) begin
                errors++;
                $display("FAIL reads_missing got %0d pending required 0", rq.size());
            end
            checks++;
            if (pq.size() != 0) begin
                errors++;
                $display("FAIL probes_missing got %0d pending required 0", pq.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog cyc=%0d bench did not finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int order [6];
        order = '{0, 1, 2, 0, 1, 2};

        arstz     = 1'b0;
        req       = '1;
        req_we    = '1;
        sticky    = '0;
        inj_valid = 1'b0;
        inj_data  = '0;
        done      = 1'b0;
        for (int k = 0; k < int'(NR); k++) begin
            req_addr[k] = AW'(16'h10 * (k + 1));
            req_din[k]  = 32'hC0DE_0000 + 32'(k);
        end

        // Reset held 3 cycles with every requester asserted
        @(posedge clk);
        #1;
        for (int c = 1; c <= 3; c++) push_p(c, PK_RST, 32'h0);
        step(); step(); step();

        // Write burst right after release: 0,1,2,3 on consecutive cycles
        arstz = 1'b1;
        t = cyc;
        for (int k = 0; k < int'(NR); k++)
            push_g(t + k, k, AW'(16'h10 * (k + 1)), 1'b1, 32'hC0DE_0000 + 32'(k));
        repeat (4) step();

        // Read by requester 2 of preloaded word
        t = cyc;
        req_we[2] = 1'b0; req_addr[2] = 16'h0080; req_din[2] = 32'h1234_5678; req[2] = 1'b1;
        push_g(t, 2, 16'h0080, 1'b0, 32'h1234_5678);
        push_r(t + 4, 2, 32'hDEAD_BEEF);
        push_p(t, PK_BUSY, 32'h0);
        push_p(t, PK_ADDR, 32'h80);
        for (int i = 1; i <= 3; i++) begin
            push_p(t + i, PK_BUSY, 32'h1);
            push_p(t + i, PK_ADDR, 32'h80);
            push_p(t + i, PK_EN, 32'h0);
        end
        push_p(t + 4, PK_BUSY, 32'h0);
        repeat (5) step();

        // Read by 1 (returns word written by requester 0), write by 3 pending
        t = cyc;
        req_we[1] = 1'b0; req_addr[1] = 16'h0010; req_din[1] = 32'h0; req[1] = 1'b1;
        push_g(t, 1, 16'h0010, 1'b0, 32'h0);
        push_r(t + 4, 1, 32'hC0DE_0000);
        step();
        req_we[3] = 1'b1; req_addr[3] = 16'h0200; req_din[3] = 32'h55AA_55AA; req[3] = 1'b1;
        for (int i = 1; i <= 3; i++) push_p(t + i, PK_BUSY, 32'h1);
        push_g(t + 4, 3, 16'h0200, 1'b1, 32'h55AA_55AA);
        repeat (4) step();

        // Fairness: 0,1,2 keep requesting writes; pointer starts at 0
        t = cyc;
        for (int k = 0; k < 3; k++) begin
            req_we[k]   = 1'b1;
            req_addr[k] = AW'(16'h100 + 4 * k);
            req_din[k]  = 32'hF000_0000 + 32'(k);
        end
        sticky = 4'b0111;
        req    = 4'b0111;
        for (int i = 0; i < 6; i++)
            push_g(t + i, order[i], AW'(16'h100 + 4 * order[i]), 1'b1, 32'hF000_0000 + 32'(order[i]));
        repeat (6) step();
        req    = '0;
        sticky = '0;
        step();

        // Reset during a read: no return, stale valid ignored, next read normal
        t = cyc;
        req_we[0] = 1'b0; req_addr[0] = 16'h0080; req_din[0] = 32'h0; req[0] = 1'b1;
        push_g(t, 0, 16'h0080, 1'b0, 32'h0);
        push_p(t + 1, PK_BUSY, 32'h1);
        step();
        step();
        arstz = 1'b0;
        push_p(t + 2, PK_EN, 32'h0);
        push_p(t + 2, PK_NORV, 32'h0);
        step();
        inj_valid = 1'b1;
        inj_data  = 32'hBAD0_BAD0;
        push_p(t + 3, PK_BUSY, 32'h0);
        push_p(t + 3, PK_NORV, 32'h0);
        step();
        inj_valid = 1'b0;
        arstz     = 1'b1;
        req_we[2] = 1'b0; req_addr[2] = 16'h0080; req_din[2] = 32'h0; req[2] = 1'b1;
        push_p(t + 4, PK_NORV, 32'h0);
        push_g(t + 4, 2, 16'h0080, 1'b0, 32'h0);
        for (int i = 5; i <= 7; i++) push_p(t + i, PK_NORV, 32'h0);
        push_r(t + 8, 2, 32'hDEAD_BEEF);
        repeat (6) step();

        done = 1'b1;
    end

endmodule

// File: doc/cnnip_mem_arbiter.md
# cnnip_mem_arbiter

Round-robin arbiter that shares one port of the true dual-port block-memory wrapper among NUM_REQ requesters, such as the DMA engine, the conv PE array loader and the output writer. It drives a cnnip_mem_if master toward the wrapper and serializes accesses. Writes complete in one cycle. Reads are held open until the wrapper's valid pulse, and the read data is then returned to the requester that issued the read.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 16, byte address width; word address is addr[ADDR_WIDTH-1:2]
- DATA_WIDTH, 32, memory word width
- READ_LATENCY, 3, latency configured in the wrapper (1..3); used only by assertions

Ports:
- clk_a  in  1  clock; one clock; reset is synchronous and active-low
- arstz_aq  in  1  reset, sampled on posedge clk_a (synchronous, active-low)
- req  in  NUM_REQ  per-requester access request, held until gnt
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ x ADDR_WIDTH  byte address
- req_din  in  NUM_REQ x DATA_WIDTH  write data
- gnt  out  NUM_REQ  one-hot, one-cycle accept pulse
- rvalid  out  NUM_REQ  one-hot, one-cycle read-data-valid pulse
- rdata  out  DATA_WIDTH  read data, shared bus, qualified by rvalid
- busy  out  1  read outstanding
- mem_if  cnnip_mem_if.master  en/we/addr/din out, dout/valid in

## Operation
- FSM states are ARB and RD_WAIT. Reset state is ARB.
- **ARB:**
  - The picker selects the first asserted req at or after ptr, wrapping modulo NUM_REQ.
  - If no req is asserted: en=0 and the FSM stays in ARB.
  - On a winner k: gnt[k]=1 combinationally, en=1, we=req_we[k], addr=req_addr[k], din=req_din[k], and ptr <= (k+1) mod NUM_REQ.
  - Winner is a write: the FSM stays in ARB, so back-to-back writes are allowed every cycle.
  - Winner is a read: addr is latched into addr_q, owner_q <= k, and the FSM goes to RD_WAIT.
- **RD_WAIT:**
  - Outputs are en=0 and we=0, and mem_if.addr = addr_q, held stable because the wrapper keeps the memory enabled while it waits.
  - gnt is all zero.
  - When mem_if.valid=1: rdata <= mem_if.dout, rvalid[owner_q] <= 1 on the next cycle, and the FSM returns to ARB.
- **Handshake rules:**
  - A requester holds req, req_we, req_addr and req_din stable until gnt.
  - A reader keeps or drops req after its gnt; it may re-request immediately.
  - A requester has at most one read outstanding.
- **valid in ARB:** mem_if.valid seen while in ARB is ignored (possible after reset mid-read). It is flagged by the assertion "spurious_valid".
- **mem_if.din in RD_WAIT:** don't-care; drive zero.

## Timing
- **Reset values:** gnt=0, rvalid=0, rdata=0, busy=0, mem_if.en=0, mem_if.we=0, mem_if.addr=0, mem_if.din=0, ptr=0, state=ARB.
- **Write:** gnt and en in the same cycle T as req is sampled. The next request can be granted at T+1.
- **Read timing** (grant in cycle T):
  - wrapper valid arrives at T+READ_LATENCY;
  - rvalid/rdata are registered and appear at T+READ_LATENCY+1;
  - the earliest next grant is T+READ_LATENCY+1, so the read slot occupies READ_LATENCY+1 cycles.
- **busy:** 1 from T+1 through the valid cycle T+READ_LATENCY inclusive.
- **Requests during RD_WAIT:** they wait; the pointer does not move.
- **Fairness:** the worst-case wait for a requester is NUM_REQ-1 grants.
- **Reset during RD_WAIT:** the FSM returns to ARB, the read is dropped and no rvalid is issued. The wrapper's own reset must be asserted together with this block.
- **Timeout:** an assertion fires if valid does not arrive within READ_LATENCY cycles of a read grant.

## Structure
- **Package cnnip_arb_pkg:**
  - state enum arb_state_e {ARB, RD_WAIT};
  - localparam PTR_W = $clog2(NUM_REQ) as a function;
  - default NUM_REQ and DATA_WIDTH.
- **Sub-module cnnip_rr_pick:**
  - purely combinational;
  - inputs: req vector and ptr; outputs: onehot winner, index, any.
- The top level holds the FSM, pointer, latches and registered return path.

## Test plan
- **Reset:** hold arstz_aq=0 for 3 cycles with all req=1 -> gnt=0, rvalid=0, mem_if.en=0 throughout. First grant goes to requester 0 on the first cycle after release.
- **Write burst:** req[0..3]=1, all writes, addr 0x10/0x20/0x30/0x40 -> gnt 0,1,2,3 on four consecutive cycles. mem_if.addr follows the same sequence, we=1.
- **Read, READ_LATENCY=3:** requester 2 reads 0x0080, memory word 0x20 preloaded with 0xDEADBEEF.
  - gnt[2] at T; busy at T+1..T+3; rvalid[2]=1 with rdata=0xDEADBEEF at T+4.
  - mem_if.addr=0x0080 during T..T+3.
- **Mixed read and write:** requester 1 reads while requester 3's write is pending -> write gnt[3] at T+4, not earlier. ptr then points to 0.
- **Fairness:** requester 0 re-requests continuously while 1 and 2 are asserted -> grant order 0,1,2,0,1,2; no requester is starved.
- **Reset mid-read:** reset at T+2 after a read grant -> no rvalid. A late valid pulse is ignored. The next read completes normally.
